// File: rtl/systolic_result_drain.sv
// Result drain for the systolic matmul array: snapshots the flat result
// matrix on result_valid and streams the active eff_size x eff_size
// sub-matrix row-major over valid/ready, narrowing each element with
// optional saturation.
module systolic_result_drain #(
   parameter int SIZE       = 4,
   parameter int DATA_WIDTH = 8,
   parameter int OUT_WIDTH  = 16,
   parameter int SIGNED     = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 result_valid,
   input  logic [SIZE*SIZE*2*DATA_WIDTH-1:0]    result_matrix,
   input  logic [$clog2(SIZE+1)-1:0]            matrix_size,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [OUT_WIDTH-1:0]                 out_data,
   output logic [$clog2(SIZE)-1:0]              out_row,
   output logic [$clog2(SIZE)-1:0]              out_col,
   output logic                                 out_last,
   output logic                                 out_sat,
   output logic                                 busy,
   output logic                                 overrun,
   input  logic                                 overrun_clr
);

   localparam int EW  = 2 * DATA_WIDTH;
   localparam int SW  = $clog2(SIZE + 1);
   localparam int IW  = $clog2(SIZE);
   localparam int NEL = SIZE * SIZE;
   localparam int XW  = $clog2(NEL);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   row_q, row_d;
   logic [IW-1:0]   col_q, col_d;
   logic [IW-1:0]   eff_m1_q, eff_m1_d;
   logic            overrun_q, overrun_d;
   logic [EW-1:0]   snap_q [NEL];

   logic            in_drain;
   logic            xfer;
   logic            last_beat;
   logic            last_xfer;
   logic            load;
   logic [XW-1:0]   idx;
   logic [EW-1:0]   elem;
   logic [OUT_WIDTH-1:0] conv_data;
   logic            conv_sat;

   // Handshake qualifiers and snapshot-accept decision
   always_comb begin
      in_drain  = (state_q == DRAIN);
      last_beat = (row_q == eff_m1_q) && (col_q == eff_m1_q);
      xfer      = in_drain && out_ready;
      last_xfer = xfer && last_beat;
      load      = result_valid && (matrix_size != '0) && (!in_drain || last_xfer);
   end

   // Next-state: FSM, element position, effective size and sticky overrun
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      eff_m1_d  = eff_m1_q;
      overrun_d = overrun_q;

      // Set is evaluated after clear so a coincident set wins.
      if (overrun_clr) begin
         overrun_d = 1'b0;
      end
      if (result_valid && in_drain && !last_xfer) begin
         overrun_d = 1'b1;
      end

      if (load) begin
         state_d = DRAIN;
         row_d   = '0;
         col_d   = '0;
         if (matrix_size >= SW'(SIZE)) begin
            eff_m1_d = IW'(SIZE - 1);
         end else begin
            eff_m1_d = IW'(matrix_size - SW'(1));
         end
      end else if (last_xfer) begin
         state_d = IDLE;
         row_d   = '0;
         col_d   = '0;
      end else if (xfer) begin
         if (col_q == eff_m1_q) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // Control state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         row_q     <= '0;
         col_q     <= '0;
         eff_m1_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         eff_m1_q  <= eff_m1_d;
         overrun_q <= overrun_d;
      end
   end

   // Snapshot capture; contents are only meaningful while draining
   always_ff @(posedge clk) begin
      if (load) begin
         for (int unsigned k = 0; k < NEL; k++) begin
            snap_q[k] <= result_matrix[k*EW +: EW];
         end
      end
   end

   // Select the current element of the snapshot
   always_comb begin
      idx  = XW'(row_q) * XW'(SIZE) + XW'(col_q);
      elem = snap_q[idx];
   end

   generate
      if (OUT_WIDTH >= EW) begin : g_widen
         if (SIGNED != 0) begin : g_sext
            // Sign-extend into the wider output
            always_comb begin
               conv_sat  = 1'b0;
               conv_data = OUT_WIDTH'($signed(elem));
            end
         end else begin : g_zext
            // Zero-extend into the wider output
            always_comb begin
               conv_sat  = 1'b0;
               conv_data = OUT_WIDTH'(elem);
            end
         end
      end else if (SIGNED != 0) begin : g_clip_s
         logic [EW-OUT_WIDTH:0] top;
         assign top = elem[EW-1:OUT_WIDTH-1];
         // Signed clip: in range when all dropped bits match the kept sign bit
         always_comb begin
            conv_sat  = 1'b0;
            conv_data = elem[OUT_WIDTH-1:0];
            if ((top != '0) && (top != '1)) begin
               conv_sat  = 1'b1;
               conv_data = elem[EW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
         end
      end else begin : g_clip_u
         // Unsigned clip: any set bit above the output width saturates to max
         always_comb begin
            conv_sat  = 1'b0;
            conv_data = elem[OUT_WIDTH-1:0];
            if (elem[EW-1:OUT_WIDTH] != '0) begin
               conv_sat  = 1'b1;
               conv_data = '1;
            end
         end
      end
   endgenerate

   // Stream outputs; element-derived fields are forced to zero when idle
   always_comb begin
      out_valid = in_drain;
      busy      = in_drain;
      out_row   = row_q;
      out_col   = col_q;
      out_data  = in_drain ? conv_data : '0;
      out_sat   = in_drain && conv_sat;
      out_last  = in_drain && last_beat;
      overrun   = overrun_q;
   end

endmodule
